clock_period_meter: RTL and testbench
=====================================

# clock_period_meter

Measures the period and high time of a slow, asynchronous square wave in clk_in cycles. It is the receiving end of the divided clocks produced by clock_divider. It serves as an on-chip self-check of divider outputs and as a general frequency/duty monitor. Results are published as registered words with a one-cycle valid strobe, plus a sticky timeout flag for a stalled input.

## Interface
- WIDTH, 32: width of the cycle counter and of the period/high_time outputs.
- TIMEOUT, 1048576: clk_in cycles without a rising edge on sig_in before timeout is declared; must be ≥ 4 and < 2**WIDTH.

- clk_in  input  1  measurement clock; all logic on its rising edge.
- nrst  input  1  reset, asynchronous, active-low.
- sig_in  input  1  signal under measurement, asynchronous to clk_in.
- enable  input  1  measurement enable; low forces IDLE.
- period  output  WIDTH  clk_in cycles between consecutive sig_in rising edges.
- high_time  output  WIDTH  clk_in cycles from a rising edge to the following falling edge.
- valid  output  1  one-cycle strobe; period/high_time updated in the same cycle.
- timeout  output  1  sticky; no rising edge within TIMEOUT cycles.

## Operation
- sig_in passes through a 2-FF synchronizer, then a previous-value register. rise/fall are single-cycle pulses from the synchronized value.
- cnt (WIDTH bits) saturates at all-ones and never wraps.
- IDLE:
  - Entered on reset or whenever enable=0.
  - cnt=0, timeout cleared; period/high_time hold their last values.
  - enable=1 → ARM.
- ARM:
  - Waits for the first rise, discarding any partial period.
  - rise → MEASURE with cnt=1. No valid is issued for this first edge.
  - cnt reaching TIMEOUT → timeout=1, cnt=0, stay in ARM.
- MEASURE:
  - cnt increments each cycle.
  - fall → capture hi_cap=cnt.
  - rise → next cycle period=cnt, high_time=hi_cap, valid=1; cnt restarts at 1; timeout cleared.
  - cnt reaching TIMEOUT → timeout=1, go to ARM.
  - rise and timeout in the same cycle: rise wins, the measurement is valid, timeout stays 0.
  - A rise with no intervening fall (glitch shorter than sync resolution) gives high_time=0.
- enable falling mid-measurement: the current period is abandoned, no valid, → IDLE next cycle.
- Reset values: period=0, high_time=0, valid=0, timeout=0, state IDLE.

## Timing
- A sig_in rise first sampled at clk_in edge k gives a rise pulse at edge k+2. valid and the new period are visible after edge k+3.
- Latency from input edge to valid is therefore 3 cycles, constant, so period is exact for a steady input: jitter ≤ ±1 cycle for truly asynchronous inputs, 0 for inputs derived from clk_in.
- Minimum measurable period is 2 cycles; minimum high/low phase is 1 cycle.
- Consecutive valid pulses are at least 2 cycles apart.

## Configuration
- CLOCK_PERIOD_METER_AVG_EN defined:
  - period is the truncated mean of the last 4 measured periods (sum >> 2, sum held in WIDTH+2 bits).
  - valid is suppressed until 4 periods have been collected since entering MEASURE. The history is cleared on ARM or IDLE.
  - high_time remains the latest raw value.
- Not defined: period is the raw latest measurement, with valid from the 2nd rising edge; no averaging storage is synthesized.

## Structure
- Package clock_meter_pkg:
  - state typedef (IDLE, ARM, MEASURE).
  - SYNC_STAGES=2.
  - AVG_DEPTH=4 and AVG_SHIFT=2.
- One sub-module, edge_sync: 2-FF synchronizer plus rise/fall pulse outputs, reset asynchronously to 0.
- The top level holds the FSM, counter, capture registers and optional averager.

## Test plan
- sig_in driven by clock_divider with scale=3 (period 6, high 3), enable=1 → first valid after 2nd rising edge; period=6, high_time=3 on every subsequent valid, one valid per 6 cycles.
- 25 % duty input with period 8 (high 2) → period=8, high_time=2; no timeout.
- TIMEOUT=16, sig_in held low after one rising edge → timeout=1 at the 16th cycle after the edge, valid never asserted. Then resume a period-6 input → timeout clears with the first new valid.
- enable dropped mid-period, then raised → no valid for the interrupted period. The next valid comes only after two fresh rising edges, and timeout=0 throughout IDLE.
- nrst asserted asynchronously mid-measurement → all outputs 0 immediately and state IDLE; after release, the measurement restarts from ARM.
- With CLOCK_PERIOD_METER_AVG_EN, periods 6,6,7,7 → single valid with period=6 (26>>2). A following period of 7 → period=6 (27>>2); the next 7 → period=7.

Source files
------------

// File: rtl/clock_meter_pkg.sv
// clock_meter_pkg
//   Shared definitions for clock_period_meter and its edge_sync helper:
//   the measurement state type, synchronizer depth and averager geometry.
package clock_meter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } meter_state_t;

  localparam int SYNC_STAGES = 2;

  // Averaging window; AVG_SHIFT must equal log2(AVG_DEPTH).
  localparam int AVG_DEPTH = 4;
  localparam int AVG_SHIFT = 2;

endpackage

// File: rtl/edge_sync.sv
// edge_sync
//   Brings an asynchronous level into the clk_in domain through a
//   SYNC_STAGES flip-flop synchronizer, keeps the previous synchronized
//   value, and produces registered single-cycle rise/fall pulses.
//
// Ports
//   clk_in  : sampling clock
//   nrst    : asynchronous active-low reset, clears everything to 0
//   sig_in  : asynchronous input level
//   rise    : one-cycle pulse after a synchronized 0->1 transition
//   fall    : one-cycle pulse after a synchronized 1->0 transition
module edge_sync
  import clock_meter_pkg::*;
(
  input  logic clk_in,
  input  logic nrst,
  input  logic sig_in,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // The pulses are registered so a sig_in transition first sampled at
  // edge k shows up as a pulse right after edge k+2, a fixed latency.
  always_ff @(posedge clk_in or negedge nrst) begin
    if (!nrst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      prev_q <= sync_q[SYNC_STAGES-1];
      rise   <= sync_q[SYNC_STAGES-1] & ~prev_q;
      fall   <= ~sync_q[SYNC_STAGES-1] & prev_q;
    end
  end

endmodule

// File: rtl/clock_period_meter.sv
// clock_period_meter
//   Measures period and high time of a slow asynchronous square wave in
//   clk_in cycles. Results are published as registered words with a
//   one-cycle valid strobe; a sticky timeout flags a stalled input.
//
// Optional feature macro: CLOCK_PERIOD_METER_AVG_EN
//   When defined, period reports the truncated mean of the last
//   AVG_DEPTH measured periods and valid is withheld until that many
//   periods have been collected since entering MEASURE.
//
// Parameters
//   WIDTH   : counter and result width
//   TIMEOUT : cycles without a rising edge before timeout (4 .. 2**WIDTH-1)
//
// Ports
//   clk_in    : measurement clock
//   nrst      : asynchronous active-low reset
//   sig_in    : signal under measurement (asynchronous)
//   enable    : measurement enable, low forces IDLE
//   period    : cycles between consecutive rising edges
//   high_time : cycles from a rising edge to the following falling edge
//   valid     : one-cycle strobe, results updated in the same cycle
//   timeout   : sticky stall indication
module clock_period_meter
  import clock_meter_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 1048576
) (
  input  logic             clk_in,
  input  logic             nrst,
  input  logic             sig_in,
  input  logic             enable,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             valid,
  output logic             timeout
);

  localparam logic [WIDTH-1:0] TIMEOUT_CNT = WIDTH'(TIMEOUT);

  meter_state_t     state, next_state;
  logic [WIDTH-1:0] cnt, cnt_nxt, cnt_inc;
  logic [WIDTH-1:0] hi_cap, hi_cap_nxt;
  logic [WIDTH-1:0] period_nxt, high_nxt;
  logic             valid_nxt, timeout_nxt;
  logic             rise, fall;

  edge_sync u_edge_sync (
    .clk_in (clk_in),
    .nrst   (nrst),
    .sig_in (sig_in),
    .rise   (rise),
    .fall   (fall)
  );

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

`ifdef CLOCK_PERIOD_METER_AVG_EN
  localparam logic [1:0] FILL_FULL = 2'(AVG_DEPTH - 1);

  // Only the AVG_DEPTH-1 older periods are stored; the newest one is the
  // live counter value at the rising edge that closes it.
  logic [WIDTH-1:0] hist_q   [AVG_DEPTH-1];
  logic [WIDTH-1:0] hist_nxt [AVG_DEPTH-1];
  logic [1:0]       fill_q, fill_nxt;
  logic [WIDTH+1:0] avg_sum;
  logic [WIDTH-1:0] avg_period;

  always_comb begin
    avg_sum = {2'b00, cnt};
    for (int i = 0; i < AVG_DEPTH - 1; i++) begin
      avg_sum = avg_sum + {2'b00, hist_q[i]};
    end
    avg_period = avg_sum[WIDTH+1:AVG_SHIFT];
  end

  always_ff @(posedge clk_in or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < AVG_DEPTH - 1; i++) hist_q[i] <= '0;
      fill_q <= '0;
    end else begin
      for (int i = 0; i < AVG_DEPTH - 1; i++) hist_q[i] <= hist_nxt[i];
      fill_q <= fill_nxt;
    end
  end
`endif

  // Next-state and result logic. enable=0 overrides every state so an
  // in-flight period is dropped without a valid.
  always_comb begin
    next_state  = state;
    cnt_nxt     = cnt;
    hi_cap_nxt  = hi_cap;
    period_nxt  = period;
    high_nxt    = high_time;
    valid_nxt   = 1'b0;
    timeout_nxt = timeout;
`ifdef CLOCK_PERIOD_METER_AVG_EN
    hist_nxt = hist_q;
    fill_nxt = fill_q;
`endif

    if (!enable) begin
      next_state  = IDLE;
      cnt_nxt     = '0;
      timeout_nxt = 1'b0;
`ifdef CLOCK_PERIOD_METER_AVG_EN
      fill_nxt = '0;
      for (int i = 0; i < AVG_DEPTH - 1; i++) hist_nxt[i] = '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          next_state  = ARM;
          cnt_nxt     = '0;
          timeout_nxt = 1'b0;
        end

        // The first rise only starts the clock; any partial period seen
        // before it is meaningless.
        ARM: begin
`ifdef CLOCK_PERIOD_METER_AVG_EN
          fill_nxt = '0;
          for (int i = 0; i < AVG_DEPTH - 1; i++) hist_nxt[i] = '0;
`endif
          if (rise) begin
            next_state = MEASURE;
            cnt_nxt    = WIDTH'(1);
            hi_cap_nxt = '0;
          end else if (cnt == TIMEOUT_CNT) begin
            timeout_nxt = 1'b1;
            cnt_nxt     = '0;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end

        // A rise is checked before the timeout so a period of exactly
        // TIMEOUT cycles still counts as a measurement. hi_cap is cleared
        // on every rise so a rise without a fall reports high_time=0.
        MEASURE: begin
          if (rise) begin
            cnt_nxt     = WIDTH'(1);
            hi_cap_nxt  = '0;
            timeout_nxt = 1'b0;
`ifdef CLOCK_PERIOD_METER_AVG_EN
            hist_nxt[0] = cnt;
            for (int i = 1; i < AVG_DEPTH - 1; i++) hist_nxt[i] = hist_q[i-1];
            if (fill_q == FILL_FULL) begin
              valid_nxt  = 1'b1;
              period_nxt = avg_period;
              high_nxt   = hi_cap;
            end else begin
              fill_nxt = fill_q + 2'd1;
            end
`else
            valid_nxt  = 1'b1;
            period_nxt = cnt;
            high_nxt   = hi_cap;
`endif
          end else if (cnt == TIMEOUT_CNT) begin
            timeout_nxt = 1'b1;
            next_state  = ARM;
            cnt_nxt     = '0;
          end else begin
            cnt_nxt = cnt_inc;
            if (fall) hi_cap_nxt = cnt;
          end
        end

        default: begin
          next_state = IDLE;
          cnt_nxt    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge nrst) begin
    if (!nrst) begin
      state     <= IDLE;
      cnt       <= '0;
      hi_cap    <= '0;
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= next_state;
      cnt       <= cnt_nxt;
      hi_cap    <= hi_cap_nxt;
      period    <= period_nxt;
      high_time <= high_nxt;
      valid     <= valid_nxt;
      timeout   <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_clock_period_meter.sv
// tb_clock_period_meter
//   Self-checking bench for clock_period_meter (WIDTH=16, TIMEOUT=16).
//   A reference model records when each sig_in edge is first sampled and
//   derives the expected valid cycle, period and high time from the
//   distances between those edges. Honours CLOCK_PERIOD_METER_AVG_EN.
module tb_clock_period_meter;

  localparam int WIDTH   = 16;
  localparam int TIMEOUT = 16;
  localparam int LAT     = 3;

  logic             clk_in = 1'b0;
  logic             nrst   = 1'b0;
  logic             sig_in = 1'b0;
  logic             enable = 1'b0;
  logic [WIDTH-1:0] period;
  logic [WIDTH-1:0] high_time;
  logic             valid;
  logic             timeout;

  clock_period_meter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk_in    (clk_in),
    .nrst      (nrst),
    .sig_in    (sig_in),
    .enable    (enable),
    .period    (period),
    .high_time (high_time),
    .valid     (valid),
    .timeout   (timeout)
  );

  always #5 clk_in = ~clk_in;

  // cyc = number of rising clock edges seen so far
  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check_output(input string tag, input logic [31:0] got,
                              input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0d expected %0d at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // Reference model: one expected result per completed period.
  typedef struct {
    int at_cyc;
    int per;
    int hi;
  } exp_t;

  exp_t exp_q[$];
  int   hist[$];
  int   last_rise = -1;
  int   last_fall = -1;
  int   last_per  = 0;
  int   last_hi   = 0;
  bit   mon_en    = 1'b0;

  function automatic void model_reset();
    last_rise = -1;
    last_fall = -1;
    hist.delete();
  endfunction

  function automatic void model_rise(input int k);
    int p, h, s;
    exp_t e;
    if (last_rise >= 0) begin
      p = k - last_rise;
      h = (last_fall > last_rise) ? last_fall - last_rise : 0;
`ifdef CLOCK_PERIOD_METER_AVG_EN
      hist.push_back(p);
      if (hist.size() > 4) void'(hist.pop_front());
      if (hist.size() == 4) begin
        s = 0;
        foreach (hist[i]) s += hist[i];
        e.at_cyc = k + LAT; e.per = s / 4; e.hi = h;
        exp_q.push_back(e);
        last_per = e.per; last_hi = h;
      end
`else
      s = 0;
      e.at_cyc = k + LAT; e.per = p; e.hi = h;
      exp_q.push_back(e);
      last_per = p; last_hi = h;
`endif
    end
    last_rise = k;
  endfunction

  function automatic void model_fall(input int k);
    last_fall = k;
  endfunction

  // Per-cycle monitor: valid must pulse exactly on the predicted cycles.
  always @(negedge clk_in) begin
    if (mon_en && nrst) begin
      if (exp_q.size() > 0 && exp_q[0].at_cyc == cyc) begin
        check_output("valid_pulse", 32'(valid), 32'd1);
        check_output("period", 32'(period), 32'(exp_q[0].per));
        check_output("high_time", 32'(high_time), 32'(exp_q[0].hi));
        void'(exp_q.pop_front());
      end else begin
        check_output("valid_idle", 32'(valid), 32'd0);
      end
    end
  end

  // Drives n periods of p cycles with h cycles high; each input change is
  // first sampled at the edge after it is applied.
  task automatic apply_stimulus(input int p, input int h, input int n);
    logic v;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < p; j++) begin
        @(posedge clk_in);
        #1;
        v = (j < h);
        if (v !== sig_in) begin
          sig_in = v;
          if (v) model_rise(cyc + 1);
          else   model_fall(cyc + 1);
        end
      end
    end
  endtask

  task automatic wait_cycle(input int target);
    while (cyc < target) @(negedge clk_in);
  endtask

  // Lets in-flight edges settle, then cycles enable to restart from ARM.
  task automatic reidle();
    repeat (5) @(posedge clk_in);
    #1;
    enable = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_in);
    #1;
    enable = 1'b1;
  endtask

  int c0;
  int pr, hr;

  initial begin
    // Reset state
    #12;
    check_output("rst_period", 32'(period), 32'd0);
    check_output("rst_high", 32'(high_time), 32'd0);
    check_output("rst_valid", 32'(valid), 32'd0);
    check_output("rst_timeout", 32'(timeout), 32'd0);
    @(posedge clk_in);
    #1;
    nrst   = 1'b1;
    enable = 1'b1;
    mon_en = 1'b1;

    // Divider-style 50 % input, then 25 % duty
    apply_stimulus(6, 3, 8);
    apply_stimulus(8, 2, 6);
    check_output("no_timeout_steady", 32'(timeout), 32'd0);

    // Averaging sequence (periods 6,6,7,7,7,7,6); raw values without the macro
    reidle();
    apply_stimulus(6, 3, 2);
    apply_stimulus(7, 3, 4);
    apply_stimulus(6, 3, 2);

    // Extremes: minimum period and a period of exactly TIMEOUT
    reidle();
    apply_stimulus(2, 1, 6);
    apply_stimulus(16, 8, 3);
    apply_stimulus(6, 3, 1);
    check_output("rise_beats_timeout", 32'(timeout), 32'd0);

    // Stall: one rise then sig_in held low
    reidle();
    @(posedge clk_in);
    #1;
    c0 = cyc;
    sig_in = 1'b1;
    model_rise(c0 + 1);
    repeat (3) @(posedge clk_in);
    #1;
    sig_in = 1'b0;
    model_fall(cyc + 1);
    wait_cycle(c0 + LAT + TIMEOUT);
    check_output("timeout_before", 32'(timeout), 32'd0);
    wait_cycle(c0 + LAT + TIMEOUT + 1);
    check_output("timeout_set", 32'(timeout), 32'd1);
    model_reset();
    repeat (10) @(posedge clk_in);
    #1;
    check_output("timeout_sticky", 32'(timeout), 32'd1);

    // Resume a period-6 input: timeout holds until the first new measurement
    c0 = cyc;
    fork
      apply_stimulus(6, 3, 6);
      begin
        wait_cycle(c0 + 7 + LAT);
        check_output("timeout_hold", 32'(timeout), 32'd1);
        wait_cycle(c0 + 8 + LAT);
        check_output("timeout_clear", 32'(timeout), 32'd0);
      end
    join

    // enable dropped mid-period
    reidle();
    apply_stimulus(6, 3, 3);
    apply_stimulus(5, 3, 1);
    enable = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_in);
      check_output("idle_timeout", 32'(timeout), 32'd0);
    end
    check_output("idle_hold_period", 32'(period), 32'(last_per));
    check_output("idle_hold_high", 32'(high_time), 32'(last_hi));
    @(posedge clk_in);
    #1;
    enable = 1'b1;
    apply_stimulus(6, 3, 4);

    // Asynchronous reset mid-measurement
    apply_stimulus(4, 3, 1);
    @(posedge clk_in);
    #3;
    nrst   = 1'b0;
    sig_in = 1'b0;
    exp_q.delete();
    model_reset();
    last_per = 0;
    last_hi  = 0;
    #1;
    check_output("arst_period", 32'(period), 32'd0);
    check_output("arst_high", 32'(high_time), 32'd0);
    check_output("arst_valid", 32'(valid), 32'd0);
    check_output("arst_timeout", 32'(timeout), 32'd0);
    repeat (2) @(posedge clk_in);
    #1;
    nrst = 1'b1;
    apply_stimulus(6, 3, 4);

    // Randomized periods and duty cycles
    reidle();
    for (int i = 0; i < 40; i++) begin
      pr = int'($urandom_range(16, 2));
      hr = int'($urandom_range(pr - 1, 1));
      apply_stimulus(pr, hr, 1);
    end
    apply_stimulus(6, 3, 1);
    check_output("random_no_timeout", 32'(timeout), 32'd0);

    repeat (8) @(posedge clk_in);
    @(negedge clk_in);
    check_output("all_results_seen", 32'(exp_q.size()), 32'd0);
    mon_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("[TB] FAIL watchdog got %0d expected %0d", cyc, 0);
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "[TB] simulation time limit");
  end

endmodule
